// File: rtl/tx_frame_gen_if.sv
// AXI-Stream byte channel between the frame generator and the MAC.
// master drives data/valid/last, slave returns ready.
interface tx_frame_gen_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/tx_frame_gen.sv
// Ethernet TX frame builder: 14-byte header, payload from a FWFT buffer,
// zero padding up to the 46-byte minimum payload, streamed over AXI-Stream.
module tx_frame_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [10:0] payload_len,
  input  logic [7:0]  btx_data,
  input  logic        btx_empty,
  output logic        btx_rd_en,
  tx_frame_gen_if.master tx_axis,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER_BYTES,
    DATA_BYTES,
    PAD_BYTES
  } state_t;

  localparam logic [10:0] MAX_LEN = 11'd1500;
  localparam logic [10:0] MIN_LEN = 11'd46;

  state_t      state_q, state_d;
  logic [47:0] dst_q, src_q;
  logic [15:0] type_q;
  logic [10:0] len_q;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [10:0] dcnt_q, dcnt_d;
  logic        done_q, done_d;
  logic        cap;
  logic [10:0] eff_len;
  logic [111:0] hdr_sh;
  logic        data_last;
  logic        long_frame;

  assign eff_len = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
  assign hdr_sh  = {dst_q, src_q, type_q} << {hcnt_q, 3'b000};
  assign data_last  = (dcnt_q == len_q - 11'd1);
  assign long_frame = (len_q >= MIN_LEN);

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dst_q   <= '0;
      src_q   <= '0;
      type_q  <= '0;
      len_q   <= '0;
      hcnt_q  <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      if (cap) begin
        dst_q  <= dst_mac;
        src_q  <= src_mac;
        type_q <= eth_type;
        len_q  <= eff_len;
      end
    end
  end

  // dcnt keeps running through padding so the pad ends when it reaches 45.
  always_comb begin
    state_d        = state_q;
    hcnt_d         = hcnt_q;
    dcnt_d         = dcnt_q;
    done_d         = 1'b0;
    cap            = 1'b0;
    btx_rd_en      = 1'b0;
    tx_axis.tvalid = 1'b0;
    tx_axis.tlast  = 1'b0;
    tx_axis.tdata  = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          cap     = 1'b1;
          hcnt_d  = '0;
          dcnt_d  = '0;
          state_d = HEADER_BYTES;
        end
      end
      HEADER_BYTES: begin
        tx_axis.tvalid = 1'b1;
        tx_axis.tdata  = hdr_sh[111:104];
        if (tx_axis.tready) begin
          if (hcnt_q == 4'd13) begin
            hcnt_d  = '0;
            state_d = (len_q != '0) ? DATA_BYTES
                                    : PAD_BYTES;
          end else begin
            hcnt_d = hcnt_q + 4'd1;
          end
        end
      end
      DATA_BYTES: begin
        tx_axis.tvalid = !btx_empty;
        tx_axis.tdata  = btx_data;
        tx_axis.tlast  = data_last && long_frame;
        btx_rd_en      = !btx_empty && tx_axis.tready;
        if (btx_rd_en) begin
          dcnt_d = dcnt_q + 11'd1;
          if (data_last) begin
            if (long_frame) begin
              dcnt_d  = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PAD_BYTES;
            end
          end
        end
      end
      PAD_BYTES: begin
        tx_axis.tvalid = 1'b1;
        tx_axis.tlast  = (dcnt_q == MIN_LEN - 11'd1);
        if (tx_axis.tready) begin
          dcnt_d = dcnt_q + 11'd1;
          if (tx_axis.tlast) begin
            dcnt_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_frame_gen.sv
// Scoreboarded bench for tx_frame_gen: a FWFT payload buffer model,
// a beat monitor and one task per scenario.
module tb_tx_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] eth_type = '0;
  logic [10:0] payload_len = '0;
  logic [7:0]  btx_data = '0;
  logic        btx_empty = 1'b1;
  logic        btx_rd_en;
  logic        busy;
  logic        done;

  tx_frame_gen_if tx_axis ();

  tx_frame_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .eth_type    (eth_type),
    .payload_len (payload_len),
    .btx_data    (btx_data),
    .btx_empty   (btx_empty),
    .btx_rd_en   (btx_rd_en),
    .tx_axis     (tx_axis),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] fifo[$];
  logic [7:0] src_q[$];
  bit   gaps = 0;
  bit   stall = 0;
  bit   pop_req = 0;
  int   pop_cnt = 0;
  int   hs_cnt = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  bit   prev_stall = 0;
  logic [8:0] prev_beat = '0;
  logic [8:0] mon_e;
  logic [8:0] mon_b;
  logic [7:0] drv_b;

  localparam logic [47:0] DST_A = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A = 48'h000A_3501_0203;
  localparam logic [47:0] DST_B = 48'h0200_1122_3344;

  // Monitor: handshakes are sampled at negedge and complete at next posedge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_stall = 0;
      pop_req = 0;
    end else begin
      mon_b = {tx_axis.tlast, tx_axis.tdata};
      if (prev_stall) begin
        checks++;
        if (!tx_axis.tvalid || mon_b !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h",
                   tx_axis.tvalid, mon_b, prev_beat);
        end
      end
      if (btx_empty) begin
        checks++;
        if (btx_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_when_empty: got %0b required 0", btx_rd_en);
        end
      end
      if (tx_axis.tvalid && tx_axis.tready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h required none", mon_b);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_b !== mon_e) begin
            errors++;
            $display("FAIL beat%0d: got last/data %h required %h",
                     hs_cnt, mon_b, mon_e);
          end
        end
        if (tx_axis.tlast) last_cyc = cyc;
      end
      pop_req = btx_rd_en;
      prev_stall = tx_axis.tvalid && !tx_axis.tready;
      prev_beat = mon_b;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // FWFT buffer model fed from src_q; empty only clears by a push.
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_req && rst_n) begin
      if (fifo.size() > 0) drv_b = fifo.pop_front();
      pop_cnt++;
    end
    if (src_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0))
      fifo.push_back(src_q.pop_front());
    tx_axis.tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    btx_empty = (fifo.size() == 0);
    btx_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  task automatic push_frame(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input int len);
    logic [111:0] hdr;
    logic [7:0] b;
    int eff;
    eff = (len > 1500) ? 1500 : len;
    hdr = {d, s, t};
    for (int i = 0; i < 14; i++) begin
      b = hdr[111-8*i -: 8];
      exp_q.push_back({1'b0, b});
    end
    for (int i = 0; i < eff; i++) begin
      b = 8'($urandom);
      src_q.push_back(b);
      exp_q.push_back({(eff >= 46 && i == eff - 1), b});
    end
    for (int i = eff; i < 46; i++)
      exp_q.push_back({(i == 45), 8'h00});
  endtask

  task automatic start_frame(input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input int len,
                             output int c0);
    @(posedge clk);
    #2;
    dst_mac = d;
    src_mac = s;
    eth_type = t;
    payload_len = 11'(len);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    c0 = cyc + 1;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit to);
    int n = 0;
    to = 1;
    while (n < limit && to) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) to = 0;
      n++;
    end
  endtask

  task automatic wait_preload();
    int n = 0;
    while (src_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({tx_axis.tvalid, tx_axis.tlast, btx_rd_en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got v/l/rd/busy/done %b required 00000",
               {tx_axis.tvalid, tx_axis.tlast, btx_rd_en, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame(input string nm, input logic [47:0] d,
                            input int len, input bit preload,
                            input int beats);
    int c0, p0, d0, exp_pops;
    bit to;
    exp_pops = (len > 1500) ? 1500 : len;
    push_frame(d, SRC_A, 16'h0800, len);
    if (preload) wait_preload();
    p0 = pop_cnt;
    d0 = done_cnt;
    start_frame(d, SRC_A, 16'h0800, len, c0);
    wait_done(d0, 6000, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s_timeout: got no done required done", nm);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d beats missing required 0",
               nm, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (pop_cnt - p0 != exp_pops) begin
      errors++;
      $display("FAIL %s_pops: got %0d required %0d",
               nm, pop_cnt - p0, exp_pops);
    end
    checks++;
    if (done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_at: got cyc %0d required %0d",
               nm, done_cyc, last_cyc + 1);
    end
    if (beats > 0) begin
      checks++;
      if (done_cyc != c0 + beats) begin
        errors++;
        $display("FAIL %s_length: got %0d cycles required %0d",
                 nm, done_cyc - c0, beats);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got %0d pulses required 1",
               nm, done_cnt - d0);
    end
  endtask

  task automatic test_random_stall();
    gaps = 1;
    stall = 1;
    test_frame("stall100", DST_B, 100, 0, 0);
    gaps = 0;
    stall = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_beats(input int h0, input int n);
    int k = 0;
    while (hs_cnt - h0 < n && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (hs_cnt - h0 < n) begin
      errors++;
      $display("FAIL beat_wait: got %0d required %0d", hs_cnt - h0, n);
    end
  endtask

  task automatic test_start_ignored();
    int c0, d0, h0;
    bit to;
    push_frame(DST_A, SRC_A, 16'h0800, 64);
    d0 = done_cnt;
    h0 = hs_cnt;
    start_frame(DST_A, SRC_A, 16'h0800, 64, c0);
    wait_beats(h0, 34);
    start_frame(DST_B, SRC_A, 16'h86DD, 64, c0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid: got %0b required 1", busy);
    end
    wait_done(d0, 500, to);
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_frame: got to=%0b left=%0d required 0 0",
               to, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    test_frame("new_fields", DST_B, 64, 0, 78);
  endtask

  task automatic test_reset_mid();
    int c0, p0, h0;
    push_frame(DST_A, SRC_A, 16'h0800, 64);
    h0 = hs_cnt;
    start_frame(DST_A, SRC_A, 16'h0800, 64, c0);
    wait_beats(h0, 34);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_axis.tvalid, tx_axis.tlast, btx_rd_en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: got v/l/rd/busy/done %b required 00000",
               {tx_axis.tvalid, tx_axis.tlast, btx_rd_en, busy, done});
    end
    p0 = pop_cnt;
    exp_q.delete();
    src_q.delete();
    fifo.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (pop_cnt != p0) begin
      errors++;
      $display("FAIL pop_in_reset: got %0d required 0", pop_cnt - p0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_frame("after_rst", DST_A, 64, 1, 78);
  endtask

  task automatic test_back_to_back();
    int d0, p0;
    bit to;
    push_frame(DST_B, SRC_A, 16'h0806, 0);
    push_frame(DST_B, SRC_A, 16'h0806, 0);
    d0 = done_cnt;
    p0 = pop_cnt;
    @(posedge clk);
    #2;
    dst_mac = DST_B;
    eth_type = 16'h0806;
    payload_len = 11'd0;
    start = 1'b1;
    wait_done(d0, 200, to);
    @(negedge clk);
    #1;
    checks++;
    if (to || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got to=%0b busy=%0b done=%0b required 0 0 0",
               to, busy, done);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b required 1", busy);
    end
    start = 1'b0;
    wait_done(d0 + 1, 200, to);
    checks++;
    if (to || exp_q.size() != 0 || pop_cnt != p0) begin
      errors++;
      $display("FAIL b2b_second: got to=%0b left=%0d pops=%0d required 0 0 0",
               to, exp_q.size(), pop_cnt - p0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    tx_axis.tready = 1'b0;
    test_reset();
    test_frame("basic64", DST_A, 64, 1, 78);
    test_frame("short10", DST_B, 10, 1, 60);
    test_frame("zero", DST_A, 0, 0, 60);
    test_random_stall();
    test_frame("sat1600", DST_B, 1600, 0, 0);
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_gen.md
TX_FRAME_GEN -- requirements
Module: tx_frame_gen

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-004 SHALL have port dst_mac  input  48  destination MAC, captured on accepted start.
REQ-005 SHALL have port src_mac  input  48  source MAC, captured on accepted start.
REQ-006 SHALL have port eth_type  input  16  EtherType/length, captured on accepted start.
REQ-007 SHALL have port payload_len  input  11  payload byte count, captured on accepted start.
REQ-008 SHALL have port btx_data  input  8  payload byte at head of first-word-fall-through buffer.
REQ-009 SHALL have port btx_empty  input  1  payload buffer empty; btx_data invalid when high.
REQ-010 SHALL have port btx_rd_en  output  1  pop one byte from payload buffer.
REQ-011 SHALL have port tx_axis_tdata  output  8  AXI-Stream byte to MAC.
REQ-012 SHALL have port tx_axis_tvalid  output  1  AXI-Stream valid.
REQ-013 SHALL have port tx_axis_tlast  output  1  AXI-Stream last byte of frame.
REQ-014 SHALL have port tx_axis_tready  input  1  AXI-Stream ready from MAC.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after final byte handshake.

Function
REQ-017 SHALL implement states IDLE, HEADER_BYTES, DATA_BYTES, PAD_BYTES.
REQ-018 IDLE: start=1 SHALL capture dst_mac/src_mac/eth_type/effective length and go to HEADER_BYTES next cycle; tvalid=0 in IDLE.
REQ-019 Effective length SHALL be payload_len saturated to 1500; payload_len>1500 treated as 1500.
REQ-020 HEADER_BYTES: tvalid=1 continuously; 4-bit header counter 0..13 advances only on handshake (tvalid & tready).
REQ-021 Header byte order SHALL be: bytes 0-5 dst_mac[47:40] first to [7:0]; bytes 6-11 src_mac likewise; byte 12 eth_type[15:8]; byte 13 eth_type[7:0].
REQ-022 Handshake on header byte 13 SHALL move to DATA_BYTES if effective length>0, else to PAD_BYTES.
REQ-023 DATA_BYTES: tvalid=!btx_empty, tdata=btx_data, btx_rd_en=tvalid & tready; 11-bit data counter advances per handshake.
REQ-024 btx_rd_en SHALL never assert outside DATA_BYTES nor when btx_empty=1.
REQ-025 Handshake on data byte (effective length-1): if effective length>=46 frame ends, else go to PAD_BYTES.
REQ-026 PAD_BYTES: tvalid=1, tdata=8'h00; emits (46-effective length) bytes so payload+pad totals exactly 46.
REQ-027 tlast SHALL be high exactly on the final byte of the frame (last data byte or last pad byte), never in header.
REQ-028 tdata/tlast SHALL be held stable while tvalid=1 and tready=0; once tvalid=1 it SHALL not drop before handshake.
REQ-029 After final handshake: return to IDLE, done=1 for exactly that next cycle; start is not accepted in that same cycle (accepted from the following cycle).
REQ-030 start while busy=1 SHALL be ignored; captured fields unchanged mid-frame.
REQ-031 tvalid, tlast, busy, done SHALL have no combinational path from tready; btx_rd_en may.
REQ-032 Frame length on the wire SHALL be 14+max(effective length,46) bytes.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, counters 0, captured registers 0, tvalid=0, tlast=0, btx_rd_en=0, busy=0, done=0.
REQ-034 Reset mid-frame SHALL abandon the frame without tlast; no byte popped after reset assertion.
REQ-035 Operation SHALL resume on first clk rising edge after rst_n deasserts.

Verification
REQ-036 dst=FF..FF, src=00_0A_35_01_02_03, type=0800, len=64, buffer full, tready=1 -> 78 consecutive beats, bytes 0-13 match REQ-021, tlast on beat 78, done pulse next cycle.
REQ-037 len=10, 10 bytes buffered -> 14 header + 10 data + 36 zero bytes, tlast on beat 60, exactly 10 btx_rd_en pulses.
REQ-038 len=0 -> 14 header + 46 zero bytes, btx_rd_en never asserted.
REQ-039 len=100, random tready and btx_empty gaps -> tdata/tlast stable while stalled, byte stream identical to REQ-036-style reference, 100 pops.
REQ-040 start pulsed during DATA_BYTES with new dst_mac -> ignored; next frame uses new fields only after done.
REQ-041 rst_n low at data byte 20 of 64 -> tvalid=0 same cycle, busy=0, no tlast; fresh start afterwards produces full correct frame.
